// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared definitions for the data-memory responder.
//   - XLEN and the load/store funct3 encodings
//   - dmem_state_t FSM state type
//   - byte/half sign and zero extension helpers
package dmem_responder_pkg;

    localparam int unsigned XLEN = 32;

    // Load encodings
    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    // Store encodings
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StResp
    } dmem_state_t;

    function automatic logic [XLEN-1:0] sign_extend_b(input logic [7:0] b);
        return {{(XLEN-8){b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] sign_extend_h(input logic [15:0] h);
        return {{(XLEN-16){h[15]}}, h};
    endfunction

    function automatic logic [XLEN-1:0] zero_extend_b(input logic [7:0] b);
        return {{(XLEN-8){1'b0}}, b};
    endfunction

    function automatic logic [XLEN-1:0] zero_extend_h(input logic [15:0] h);
        return {{(XLEN-16){1'b0}}, h};
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage load/store request channel.
//   req_*  : request (valid/ready handshake), we, funct3, byte address, store data
//   rsp_*  : response (valid/ready handshake), formatted load data, error flag
//   master : core side, slave : memory responder side
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_bram.sv
// dmem_bram: single-port synchronous RAM, DEPTH_WORDS x 32, byte write enables,
// registered read (read-first). Contents are not initialised.
//   clk     : clock
//   en_i    : access enable; read data register only updates when set
//   we_i    : per-byte write enable, bit k covers bits [8k+7:8k]
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data, holds while en_i is low
module dmem_bram #(
    parameter int unsigned DEPTH_WORDS = 4096,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the MEM-stage load/store channel.
// Accepts one request per handshake, optionally waits WAIT_STATES cycles, accesses
// the block RAM once, then holds the response until the core takes it.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : dmem_responder_if slave modport (request and response channels)
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_state_t   state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;

    // Latched request; only the in-range address bits are kept since the range
    // check is resolved at accept.
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          err_q;

    logic          accept;
    logic          illegal, misaligned, out_of_range, req_err;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [31:0]   lane;

    assign accept = bus.req_valid && (state_q == StIdle);

    // Request error decode
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (bus.req_we) begin
            illegal = bus.req_funct3 > F3Sw;
        end else begin
            illegal = !(bus.req_funct3 inside {F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu});
        end
        case (bus.req_funct3[1:0])
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = bus.req_addr[1:0] != 2'b00;
            default: misaligned = 1'b0;
        endcase
        out_of_range = {2'b00, bus.req_addr[XLEN-1:2]} >= 32'(DEPTH_WORDS);
        req_err      = illegal || misaligned || out_of_range;
    end

    // FSM next state
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_STATES != 0) begin
                        state_d    = StWait;
                        wait_cnt_d = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StWait: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = StAccess;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StAccess: state_d = StResp;
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            we_q       <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr[AW+1:0];
                wdata_q  <= bus.req_wdata;
                err_q    <= req_err;
            end
        end
    end

    // RAM access: one cycle in StAccess, suppressed for rejected requests
    always_comb begin
        ram_en = (state_q == StAccess) && !err_q;
        ram_we = 4'b0000;
        case (funct3_q[1:0])
            2'b00: begin
                ram_wdata = {4{wdata_q[7:0]}};
                if (ram_en && we_q) ram_we = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                ram_wdata = {2{wdata_q[15:0]}};
                if (ram_en && we_q) ram_we = 4'b0011 << addr_q[1:0];
            end
            default: begin
                ram_wdata = wdata_q;
                if (ram_en && we_q) ram_we = 4'b1111;
            end
        endcase
    end

    dmem_bram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (addr_q[AW+1:2]),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Response formatting; RAM read data holds during RESP because the RAM is
    // only enabled in StAccess, so the outputs stay stable under backpressure.
    always_comb begin
        lane          = ram_rdata >> {addr_q[1:0], 3'b000};
        bus.req_ready = state_q == StIdle;
        bus.rsp_valid = state_q == StResp;
        bus.rsp_err   = (state_q == StResp) && err_q;
        bus.rsp_rdata = '0;
        if ((state_q == StResp) && !err_q && !we_q) begin
            case (funct3_q)
                F3Lb:    bus.rsp_rdata = sign_extend_b(lane[7:0]);
                F3Lh:    bus.rsp_rdata = sign_extend_h(lane[15:0]);
                F3Lbu:   bus.rsp_rdata = zero_extend_b(lane[7:0]);
                F3Lhu:   bus.rsp_rdata = zero_extend_h(lane[15:0]);
                default: bus.rsp_rdata = ram_rdata;
            endcase
        end
    end

endmodule
